// File: rtl/gpu_mem_vram_read_pack_pkg.sv
// Shared definitions for the VRAM->CPU read packer: block geometry, pack rules
// and the pixel-select helper.
package gpu_mem_vram_read_pack_pkg;

  localparam int unsigned GPU_PIX_W   = 16;
  localparam int unsigned GPU_BLK_PIX = 16;
  localparam int unsigned GPU_BLK_W   = 256;

  typedef enum logic [2:0] {
    RULE_NONE,
    RULE_PEND_PAIR,
    RULE_PAIR,
    RULE_PARK,
    RULE_SINGLE_LAST,
    RULE_FLUSH
  } pack_rule_e;

  // Pixel n occupies bits [16n+15:16n]; {idx,4'b0} is 16*idx at the index width.
  function automatic logic [GPU_PIX_W-1:0] gpu_pix_sel(
    input logic [GPU_BLK_W-1:0] blk,
    input logic [3:0]           idx
  );
    return blk[{idx, 4'b0000} +: GPU_PIX_W];
  endfunction

endpackage

// File: rtl/gpu_mem_vram_read_pack_if.sv
// Block stream from the VRAM read engine and packed word stream to the CPU
// read FIFO; signal names are from the packer's point of view.
interface gpu_mem_vram_read_pack_if;
  import gpu_mem_vram_read_pack_pkg::*;

  logic                   data_valid_i;
  logic [GPU_BLK_W-1:0]   data_value_i;
  logic [GPU_BLK_PIX-1:0] data_mask_i;
  logic [3:0]             data_offset_i;
  logic                   data_end_line_i;
  logic                   data_final_i;
  logic                   data_accept_o;
  logic                   out_valid_o;
  logic [31:0]            out_data_o;
  logic                   out_last_o;
  logic                   out_accept_i;

  modport master (
    output data_valid_i, data_value_i, data_mask_i, data_offset_i,
           data_end_line_i, data_final_i, out_accept_i,
    input  data_accept_o, out_valid_o, out_data_o, out_last_o
  );

  modport slave (
    input  data_valid_i, data_value_i, data_mask_i, data_offset_i,
           data_end_line_i, data_final_i, out_accept_i,
    output data_accept_o, out_valid_o, out_data_o, out_last_o
  );

endinterface

// File: rtl/gpu_mem_pix_pick.sv
// Two-level priority encoder: lowest set mask bit (a) and the next one above it (b).
module gpu_mem_pix_pick
  import gpu_mem_vram_read_pack_pkg::*;
(
  input  logic [GPU_BLK_PIX-1:0] mask,
  output logic                   a_valid,
  output logic [3:0]             a_idx,
  output logic                   b_valid,
  output logic [3:0]             b_idx
);

  logic [GPU_BLK_PIX-1:0] rest;

  always_comb begin
    a_valid = 1'b0;
    a_idx   = '0;
    // Scanning downwards leaves the lowest set bit as the final assignment.
    for (int unsigned i = GPU_BLK_PIX; i > 0; i--) begin
      if (mask[i-1]) begin
        a_valid = 1'b1;
        a_idx   = 4'(i - 1);
      end
    end
  end

  always_comb begin
    rest = mask;
    if (a_valid) rest[a_idx] = 1'b0;
  end

  always_comb begin
    b_valid = 1'b0;
    b_idx   = '0;
    for (int unsigned i = GPU_BLK_PIX; i > 0; i--) begin
      if (rest[i-1]) begin
        b_valid = 1'b1;
        b_idx   = 4'(i - 1);
      end
    end
  end

endmodule

// File: rtl/gpu_mem_vram_read_pack.sv
// Packs masked 16-bit pixels from VRAM read blocks into 32-bit words for the
// CPU read FIFO, carrying an odd pixel across block and line boundaries.
module gpu_mem_vram_read_pack
  import gpu_mem_vram_read_pack_pkg::*;
#(
  parameter logic [GPU_PIX_W-1:0] PAD_VALUE = 16'h0000
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  gpu_mem_vram_read_pack_if.slave          bus,
  output logic                             busy_o
);

  logic                   hold_valid_q;
  logic [GPU_BLK_W-1:0]   blk_q;
  logic [GPU_BLK_PIX-1:0] rem_q;
  logic                   final_q;
  logic                   pend_valid_q;
  logic [GPU_PIX_W-1:0]   pend_q;
  logic                   out_valid_q;
  logic [31:0]            out_data_q;
  logic                   out_last_q;

  logic                   a_valid, b_valid;
  logic [3:0]             a_idx, b_idx;
  logic [GPU_PIX_W-1:0]   pix_a, pix_b;
  logic                   ld;
  logic                   capture;
  logic                   release_blk;
  logic                   emit;
  pack_rule_e             rule;
  logic [GPU_BLK_PIX-1:0] rem_n;
  logic                   pend_valid_n;
  logic [GPU_PIX_W-1:0]   pend_n;
  logic [31:0]            word;
  logic                   word_last;

  gpu_mem_pix_pick u_pick (
    .mask    (rem_q),
    .a_valid (a_valid),
    .a_idx   (a_idx),
    .b_valid (b_valid),
    .b_idx   (b_idx)
  );

  assign pix_a   = gpu_pix_sel(blk_q, a_idx);
  assign pix_b   = gpu_pix_sel(blk_q, b_idx);
  assign ld      = !out_valid_q || bus.out_accept_i;
  assign capture = bus.data_valid_i && !hold_valid_q;

  always_comb begin
    rule         = RULE_NONE;
    rem_n        = rem_q;
    pend_valid_n = pend_valid_q;
    pend_n       = pend_q;
    word         = '0;
    word_last    = 1'b0;
    if (hold_valid_q && ld) begin
      if (pend_valid_q && a_valid) begin
        rule         = RULE_PEND_PAIR;
        rem_n[a_idx] = 1'b0;
        pend_valid_n = 1'b0;
        word         = {pix_a, pend_q};
      end else if (!pend_valid_q && a_valid && b_valid) begin
        rule         = RULE_PAIR;
        rem_n[a_idx] = 1'b0;
        rem_n[b_idx] = 1'b0;
        word         = {pix_b, pix_a};
      end else if (!pend_valid_q && a_valid && !final_q) begin
        rule         = RULE_PARK;
        rem_n[a_idx] = 1'b0;
        pend_valid_n = 1'b1;
        pend_n       = pix_a;
      end else if (!pend_valid_q && a_valid) begin
        rule         = RULE_SINGLE_LAST;
        rem_n[a_idx] = 1'b0;
        word         = {PAD_VALUE, pix_a};
        word_last    = 1'b1;
      end else if (!a_valid && final_q && pend_valid_q) begin
        rule         = RULE_FLUSH;
        pend_valid_n = 1'b0;
        word         = {PAD_VALUE, pend_q};
        word_last    = 1'b1;
      end
      if (rule == RULE_PEND_PAIR || rule == RULE_PAIR) begin
        word_last = final_q && (rem_n == '0);
      end
    end
  end

  assign emit = (rule == RULE_PEND_PAIR) || (rule == RULE_PAIR) ||
                (rule == RULE_SINGLE_LAST) || (rule == RULE_FLUSH);

  // A final block with a pending halfword must stay held until it is flushed.
  assign release_blk = hold_valid_q && ld && (rem_n == '0) &&
                       !(final_q && pend_valid_n);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      blk_q        <= '0;
      rem_q        <= '0;
      final_q      <= 1'b0;
    end else if (capture) begin
      hold_valid_q <= 1'b1;
      blk_q        <= bus.data_value_i;
      rem_q        <= bus.data_mask_i & (16'hFFFF << bus.data_offset_i);
      final_q      <= bus.data_final_i;
    end else if (hold_valid_q) begin
      rem_q <= rem_n;
      if (release_blk) hold_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      pend_valid_q <= pend_valid_n;
      pend_q       <= pend_n;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_data_q  <= word;
      out_last_q  <= word_last;
    end else if (bus.out_accept_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.data_accept_o = !hold_valid_q;
  assign bus.out_valid_o   = out_valid_q;
  assign bus.out_data_o    = out_data_q;
  assign bus.out_last_o    = out_last_q;
  assign busy_o            = hold_valid_q || pend_valid_q || out_valid_q;

endmodule

// File: tb/tb_gpu_mem_vram_read_pack.sv
// Scoreboard bench for the VRAM read packer: stimulus pushes expected words,
// a negedge monitor pops and compares every accepted output word.
module tb_gpu_mem_vram_read_pack;
  import gpu_mem_vram_read_pack_pkg::*;

  localparam logic [15:0] PAD = 16'h0000;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  gpu_mem_vram_read_pack_if bus ();

  gpu_mem_vram_read_pack #(.PAD_VALUE(PAD)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .busy_o (busy)
  );

  exp_t        exp_q[$];
  int unsigned pop_cyc_q[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int unsigned n_pop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [255:0] mk_blk(input logic [15:0] base);
    logic [255:0] r;
    for (int n = 0; n < 16; n++) r[16*n +: 16] = base + 16'(n);
    return r;
  endfunction

  task automatic push(input logic [15:0] hi, input logic [15:0] lo, input logic last);
    exp_t e;
    e.data = {hi, lo};
    e.last = last;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid_o && bus.out_accept_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %h want none", bus.out_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_data", bus.out_data_o, e.data);
        chk("word_last", 32'(bus.out_last_o), 32'(e.last));
      end
      n_pop++;
      pop_cyc_q.push_back(cyc);
    end
  end

  // Called just after a rising edge; returns the cycle count of the capture edge.
  task automatic send(input logic [15:0] base, input logic [15:0] mask,
                      input logic [3:0] off, input logic eol, input logic fin,
                      output int unsigned cap);
    bit done = 0;
    cap = 0;
    bus.data_valid_i    = 1'b1;
    bus.data_value_i    = mk_blk(base);
    bus.data_mask_i     = mask;
    bus.data_offset_i   = off;
    bus.data_end_line_i = eol;
    bus.data_final_i    = fin;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.data_accept_o) begin
        @(posedge clk);
        #1;
        cap  = cyc;
        done = 1;
      end
    end
    bus.data_valid_i = 1'b0;
    if (!done) fail_now("send_accept");
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) fail_now(name);
  endtask

  initial begin
    int unsigned cap;
    int unsigned n0;
    bit          seen;

    rst                 = 1'b1;
    bus.data_valid_i    = 1'b0;
    bus.data_value_i    = '0;
    bus.data_mask_i     = '0;
    bus.data_offset_i   = '0;
    bus.data_end_line_i = 1'b0;
    bus.data_final_i    = 1'b0;
    bus.out_accept_i    = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_out_data", bus.out_data_o, 32'd0);
    chk("rst_out_last", 32'(bus.out_last_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data_accept", 32'(bus.data_accept_o), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Full final block: 8 back-to-back words, last on the 8th.
    pop_cyc_q.delete();
    for (int k = 0; k < 8; k++)
      push(16'h1000 + 16'(2*k + 1), 16'h1000 + 16'(2*k), k == 7);
    send(16'h1000, 16'hFFFF, 4'd0, 1'b0, 1'b1, cap);
    wait_drain("t1_drain");
    chk("t1_nwords", pop_cyc_q.size(), 32'd8);
    if (pop_cyc_q.size() == 8) begin
      chk("t1_first_latency", pop_cyc_q[0] - cap, 32'd1);
      chk("t1_span", pop_cyc_q[7] - pop_cyc_q[0], 32'd7);
    end
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // Odd count in one final block: padded last word.
    @(posedge clk); #1;
    push(16'h2001, 16'h2000, 1'b0);
    push(PAD, 16'h2002, 1'b1);
    send(16'h2000, 16'h0007, 4'd0, 1'b0, 1'b1, cap);
    wait_drain("t2_drain");
    @(negedge clk);
    chk("t2_busy_after", 32'(busy), 32'd0);

    // Pending halfword crosses an end-of-line block boundary.
    @(posedge clk); #1;
    push(16'h3100, 16'h3000, 1'b0);
    push(PAD, 16'h3101, 1'b1);
    send(16'h3000, 16'h0001, 4'd0, 1'b1, 1'b0, cap);
    repeat (3) @(negedge clk);
    chk("t3_no_flush_valid", 32'(bus.out_valid_o), 32'd0);
    chk("t3_pend_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    send(16'h3100, 16'h0003, 4'd0, 1'b0, 1'b1, cap);
    wait_drain("t3_drain");

    // Offset 4 skips the low four pixels.
    @(posedge clk); #1;
    for (int k = 2; k < 8; k++)
      push(16'h4000 + 16'(2*k + 1), 16'h4000 + 16'(2*k), k == 7);
    send(16'h4000, 16'hFFFF, 4'd4, 1'b0, 1'b1, cap);
    wait_drain("t4_drain");

    // Output back-pressure: word must hold still while not accepted.
    @(posedge clk); #1;
    bus.out_accept_i = 1'b0;
    push(16'h500F, 16'h5000, 1'b1);
    send(16'h5000, 16'h8001, 4'd0, 1'b0, 1'b1, cap);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid_o) seen = 1;
    end
    if (!seen) fail_now("t5_word_appears");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_stall_data", bus.out_data_o, 32'h500F_5000);
      chk("t5_stall_valid", 32'(bus.out_valid_o), 32'd1);
      chk("t5_block_released", 32'(bus.data_accept_o), 32'd1);
    end
    @(posedge clk); #1;
    bus.out_accept_i = 1'b1;
    wait_drain("t5_drain");

    // Reset during the third word of a transfer carrying a pending pixel.
    @(posedge clk); #1;
    push(16'h6000, 16'h5800, 1'b0);
    for (int k = 0; k < 7; k++)
      push(16'h6000 + 16'(2*k + 2), 16'h6000 + 16'(2*k + 1), 1'b0);
    push(PAD, 16'h600F, 1'b1);
    n0 = n_pop;
    send(16'h5800, 16'h0001, 4'd0, 1'b0, 1'b0, cap);
    send(16'h6000, 16'hFFFF, 4'd0, 1'b0, 1'b1, cap);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (n_pop == n0 + 2) seen = 1;
    end
    if (!seen) fail_now("t6_two_words");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("t6_rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("t6_rst_out_data", bus.out_data_o, 32'd0);
    chk("t6_rst_out_last", 32'(bus.out_last_o), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_accept", 32'(bus.data_accept_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push(16'h7001, 16'h7000, 1'b1);
    send(16'h7000, 16'h0003, 4'd0, 1'b0, 1'b1, cap);
    wait_drain("t6_fresh_drain");
    @(negedge clk);
    chk("t6_final_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
